// File: rtl/hamming_rx_sequencer_pkg.sv
// Shared definitions for the Hamming(7,4) receive sequencer: state encoding,
// codeword/burst sizes and the bit-timer width helper.
package hamming_rx_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_BURST   = 3'd4,
        S_CAPTURE = 3'd5
    } state_t;

    localparam int CODE_BITS = 7;
    localparam int BURST_LEN = 8;

    function automatic int timer_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Two-flop synchroniser for the serial line plus a loadable down-counter
// whose expiry strobe marks bit sampling points.
module rx_bit_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_in,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          rx_s,
    output logic          expired
);

    logic          rx_meta;
    logic [TW-1:0] count;

    // The line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/hamming_rx_sequencer.sv
// Receive-side sequencer: deserialises start/7 code bits/stop, bursts each
// codeword into the serial decoder and pairs decoded nibbles into bytes.
// Back-to-back frames need CLKS_PER_BIT/2 >= 9 so burst plus capture fit in the stop-bit tail.
module hamming_rx_sequencer
    import hamming_rx_sequencer_pkg::*;
#(
    parameter int CLKS_PER_BIT     = 16,
    parameter bit LOW_NIBBLE_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx_in,
    output logic       dec_ena,
    output logic       dec_bit,
    input  logic       dec_valid,
    input  logic [3:0] dec_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int            TW        = timer_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(CODE_BITS - 1);
    localparam logic [2:0]    LAST_K    = 3'(BURST_LEN - 1);

    state_t                 state;
    state_t                 next_state;
    logic                   rx_s;
    logic                   expired;
    logic                   timer_load;
    logic [TW-1:0]          timer_val;
    logic [2:0]             bit_idx;
    logic [CODE_BITS-1:0]   code_buf;
    logic [BURST_LEN-1:0]   burst_word;
    logic [2:0]             burst_k;
    logic                   pair_flag;
    logic [3:0]             first_nib;
    logic [7:0]             assembled;
    logic                   stop_bad;
    logic                   cap_ok;
    logic                   cap_bad;

    rx_bit_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (rx_in),
        .load     (timer_load),
        .load_val (timer_val),
        .rx_s     (rx_s),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Only the IDLE->START step honours ena; a frame in flight always completes.
    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        timer_val  = FULL_LOAD;
        case (state)
            S_IDLE: begin
                if (ena && !rx_s) begin
                    next_state = S_START;
                    timer_load = 1'b1;
                    timer_val  = HALF_LOAD;
                end
            end
            S_START: begin
                if (expired) begin
                    if (!rx_s) begin
                        next_state = S_DATA;
                        timer_load = 1'b1;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (expired) begin
                    timer_load = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        next_state = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (expired) begin
                    next_state = rx_s ? S_BURST : S_IDLE;
                end
            end
            S_BURST: begin
                if (burst_k == LAST_K) begin
                    next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        burst_word = {1'b0, code_buf};
        dec_ena    = (state == S_BURST);
        dec_bit    = (state == S_BURST) ? burst_word[burst_k] : 1'b0;
        busy       = (state != S_IDLE);
        stop_bad   = (state == S_STOP) && expired && !rx_s;
        cap_ok     = (state == S_CAPTURE) && dec_valid;
        cap_bad    = (state == S_CAPTURE) && !dec_valid;
        assembled  = LOW_NIBBLE_FIRST ? {dec_data, first_nib} : {first_nib, dec_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx  <= '0;
            code_buf <= '0;
            burst_k  <= '0;
        end else begin
            if (state == S_START && expired) begin
                bit_idx <= '0;
            end else if (state == S_DATA && expired) begin
                code_buf[bit_idx] <= rx_s;
                bit_idx           <= bit_idx + 1'b1;
            end
            burst_k <= (state == S_BURST) ? burst_k + 1'b1 : 3'd0;
        end
    end

    // A byte completing against an unaccepted byte is dropped unless the old one leaves this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_flag <= 1'b0;
            first_nib <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad || cap_bad;
            overrun   <= 1'b0;
            if (stop_bad || cap_bad) begin
                pair_flag <= 1'b0;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (cap_ok) begin
                if (!pair_flag) begin
                    first_nib <= dec_data;
                    pair_flag <= 1'b1;
                end else begin
                    pair_flag <= 1'b0;
                    if (out_valid && !out_ready) begin
                        overrun <= 1'b1;
                    end else begin
                        out_data  <= assembled;
                        out_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hamming_rx_sequencer.sv
// Directed bench: two sequencers (low- and high-nibble-first) share one rx line,
// each driving its own serial Hamming(7,4) decoder model.
module tb_hamming_rx_sequencer;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       rx_in = 1'b1;
    logic       out_ready = 1'b0;

    logic       dec_ena_w   [2];
    logic       dec_bit_w   [2];
    logic       out_valid_w [2];
    logic [7:0] out_data_w  [2];
    logic       frame_err_w [2];
    logic       overrun_w   [2];
    logic       busy_w      [2];

    logic       dvalid [2];
    logic [3:0] ddata  [2];
    logic [2:0] dcnt   [2];
    logic [6:0] dshift [2];

    int         n_acc  [2] = '{0, 0};
    int         n_ferr [2] = '{0, 0};
    int         n_ovr  [2] = '{0, 0};
    int         n_dec  [2] = '{0, 0};
    logic [7:0] last_byte [2] = '{8'h00, 8'h00};

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hamming_rx_sequencer #(.CLKS_PER_BIT(CPB), .LOW_NIBBLE_FIRST(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx_in(rx_in),
        .dec_ena(dec_ena_w[0]), .dec_bit(dec_bit_w[0]),
        .dec_valid(dvalid[0]), .dec_data(ddata[0]),
        .out_data(out_data_w[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .frame_err(frame_err_w[0]), .overrun(overrun_w[0]), .busy(busy_w[0])
    );

    hamming_rx_sequencer #(.CLKS_PER_BIT(CPB), .LOW_NIBBLE_FIRST(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx_in(rx_in),
        .dec_ena(dec_ena_w[1]), .dec_bit(dec_bit_w[1]),
        .dec_valid(dvalid[1]), .dec_data(ddata[1]),
        .out_data(out_data_w[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .frame_err(frame_err_w[1]), .overrun(overrun_w[1]), .busy(busy_w[1])
    );

    // Positions 1..7 = p1 p2 d1 p4 d2 d3 d4 on code bits 0..6; d1 is the nibble LSB.
    function automatic logic [3:0] ham_decode(input logic [6:0] c);
        logic [6:0] t;
        int         syn;
        t   = c;
        syn = 4 * int'(c[3] ^ c[4] ^ c[5] ^ c[6])
            + 2 * int'(c[1] ^ c[2] ^ c[5] ^ c[6])
            +     int'(c[0] ^ c[2] ^ c[4] ^ c[6]);
        for (int b = 0; b < 7; b++) begin
            if (syn == b + 1) t[b] = ~t[b];
        end
        return {t[6], t[5], t[4], t[2]};
    endfunction

    // Serial decoder model: shifts 7 bits, flags valid on the 8th enabled cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                dcnt[i]   <= 3'd0;
                dvalid[i] <= 1'b0;
                ddata[i]  <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (dec_ena_w[i]) begin
                    if (dcnt[i] == 3'd7) begin
                        dvalid[i] <= 1'b1;
                        ddata[i]  <= ham_decode(dshift[i]);
                    end else begin
                        dshift[i][dcnt[i]] <= dec_bit_w[i];
                        dvalid[i]          <= 1'b0;
                    end
                    dcnt[i] <= dcnt[i] + 3'd1;
                end else begin
                    dvalid[i] <= 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (out_valid_w[i] && out_ready) begin
                    n_acc[i]     <= n_acc[i] + 1;
                    last_byte[i] <= out_data_w[i];
                end
                if (frame_err_w[i]) n_ferr[i] <= n_ferr[i] + 1;
                if (overrun_w[i])   n_ovr[i]  <= n_ovr[i] + 1;
                if (dec_ena_w[i])   n_dec[i]  <= n_dec[i] + 1;
            end
        end
    end

    task automatic send_frame(input logic [6:0] code, input logic stop_bit);
        logic [8:0] frame;
        frame = {stop_bit, code, 1'b0};
        for (int b = 0; b < 9; b++) begin
            rx_in = frame[b];
            repeat (CPB) @(negedge clk);
        end
        rx_in = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid_w[i] !== 1'b0) begin
                failures++; $display("FAIL reset_out_valid[%0d] got %b want 0", i, out_valid_w[i]);
            end
            checks++;
            if (out_data_w[i] !== 8'h00) begin
                failures++; $display("FAIL reset_out_data[%0d] got %h want 00", i, out_data_w[i]);
            end
            checks++;
            if ({dec_ena_w[i], dec_bit_w[i]} !== 2'b00) begin
                failures++; $display("FAIL reset_dec[%0d] got %b%b want 00", i, dec_ena_w[i], dec_bit_w[i]);
            end
            checks++;
            if ({busy_w[i], frame_err_w[i], overrun_w[i]} !== 3'b000) begin
                failures++;
                $display("FAIL reset_flags[%0d] got %b%b%b want 000", i, busy_w[i], frame_err_w[i], overrun_w[i]);
            end
        end
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic_pair();
        int         a0 [2];
        int         f0 [2];
        int         o0 [2];
        int         d0 [2];
        logic [7:0] want [2];
        want = '{8'h5A, 8'hA5};
        for (int i = 0; i < 2; i++) begin
            a0[i] = n_acc[i]; f0[i] = n_ferr[i]; o0[i] = n_ovr[i]; d0[i] = n_dec[i];
        end
        out_ready = 1'b1;
        send_frame(7'h5A, 1'b1);
        send_frame(7'h25, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (n_acc[i] - a0[i] !== 1) begin
                failures++; $display("FAIL pair_count[%0d] got %0d want 1", i, n_acc[i] - a0[i]);
            end
            checks++;
            if (last_byte[i] !== want[i]) begin
                failures++; $display("FAIL pair_byte[%0d] got %h want %h", i, last_byte[i], want[i]);
            end
            checks++;
            if ((n_ferr[i] - f0[i]) !== 0 || (n_ovr[i] - o0[i]) !== 0) begin
                failures++;
                $display("FAIL pair_flags[%0d] got ferr=%0d ovr=%0d want 0/0", i, n_ferr[i] - f0[i], n_ovr[i] - o0[i]);
            end
            checks++;
            if (n_dec[i] - d0[i] !== 16) begin
                failures++; $display("FAIL pair_burst_len[%0d] got %0d want 16", i, n_dec[i] - d0[i]);
            end
        end
    endtask

    task automatic test_frame_error();
        int         a0 [2];
        int         f0 [2];
        logic [7:0] want [2];
        want = '{8'h5A, 8'hA5};
        for (int i = 0; i < 2; i++) begin
            a0[i] = n_acc[i]; f0[i] = n_ferr[i];
        end
        out_ready = 1'b1;
        send_frame(7'h5A, 1'b1);
        send_frame(7'h25, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (n_ferr[i] - f0[i] !== 1) begin
                failures++; $display("FAIL ferr_pulse[%0d] got %0d want 1", i, n_ferr[i] - f0[i]);
            end
            checks++;
            if (n_acc[i] - a0[i] !== 0) begin
                failures++; $display("FAIL ferr_no_byte[%0d] got %0d want 0", i, n_acc[i] - a0[i]);
            end
        end
        send_frame(7'h5A, 1'b1);
        send_frame(7'h25, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (n_acc[i] - a0[i] !== 1) begin
                failures++; $display("FAIL ferr_recover_count[%0d] got %0d want 1", i, n_acc[i] - a0[i]);
            end
            checks++;
            if (last_byte[i] !== want[i]) begin
                failures++; $display("FAIL ferr_recover_byte[%0d] got %h want %h", i, last_byte[i], want[i]);
            end
        end
    endtask

    task automatic test_glitch();
        int d0;
        int f0;
        d0 = n_dec[0]; f0 = n_ferr[0];
        ena   = 1'b0;
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_w[0] !== 1'b0) begin
            failures++; $display("FAIL glitch_ena_gated got busy=%b want 0", busy_w[0]);
        end
        repeat (20) @(negedge clk);
        ena   = 1'b1;
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_w[0] !== 1'b1) begin
            failures++; $display("FAIL glitch_start_seen got busy=%b want 1", busy_w[0]);
        end
        repeat (9) @(negedge clk);
        checks++;
        if (busy_w[0] !== 1'b0) begin
            failures++; $display("FAIL glitch_busy_drop got busy=%b want 0", busy_w[0]);
        end
        checks++;
        if ((n_dec[0] - d0) !== 0 || (n_ferr[0] - f0) !== 0) begin
            failures++;
            $display("FAIL glitch_quiet got dec=%0d ferr=%0d want 0/0", n_dec[0] - d0, n_ferr[0] - f0);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int         a0 [2];
        int         o0 [2];
        logic [7:0] want [2];
        want = '{8'h5A, 8'hA5};
        for (int i = 0; i < 2; i++) begin
            a0[i] = n_acc[i]; o0[i] = n_ovr[i];
        end
        out_ready = 1'b0;
        send_frame(7'h5A, 1'b1);
        send_frame(7'h25, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({out_valid_w[i], out_data_w[i]} !== {1'b1, want[i]}) begin
                failures++;
                $display("FAIL b2b_held[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid_w[i], out_data_w[i], want[i]);
            end
        end
        send_frame(7'h25, 1'b1);
        send_frame(7'h5A, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (n_ovr[i] - o0[i] !== 1) begin
                failures++; $display("FAIL b2b_overrun[%0d] got %0d want 1", i, n_ovr[i] - o0[i]);
            end
            checks++;
            if (out_data_w[i] !== want[i]) begin
                failures++; $display("FAIL b2b_kept[%0d] got %h want %h", i, out_data_w[i], want[i]);
            end
        end
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (n_acc[i] - a0[i] !== 1 || last_byte[i] !== want[i]) begin
                failures++;
                $display("FAIL b2b_drain[%0d] got n=%0d d=%h want n=1 d=%h", i, n_acc[i] - a0[i], last_byte[i], want[i]);
            end
            checks++;
            if (out_valid_w[i] !== 1'b0) begin
                failures++; $display("FAIL b2b_valid_drop[%0d] got %b want 0", i, out_valid_w[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [8:0] frame;
        int         a0 [2];
        int         f0 [2];
        logic [7:0] want [2];
        bit         seen;
        want  = '{8'h5A, 8'hA5};
        frame = {1'b1, 7'h5A, 1'b0};
        seen  = 1'b0;
        out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            rx_in = frame[b];
            repeat (CPB) @(negedge clk);
        end
        rx_in = 1'b1;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (dec_ena_w[0]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL rst_burst_start got no dec_ena within 40 cycles want burst");
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({dec_ena_w[i], dec_bit_w[i], out_valid_w[i], frame_err_w[i], overrun_w[i], busy_w[i], out_data_w[i]} !== 14'd0) begin
                failures++;
                $display("FAIL rst_burst_outputs[%0d] got ena=%b bit=%b v=%b fe=%b ov=%b busy=%b d=%h want all 0",
                         i, dec_ena_w[i], dec_bit_w[i], out_valid_w[i], frame_err_w[i], overrun_w[i], busy_w[i],
                         out_data_w[i]);
            end
        end
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            a0[i] = n_acc[i]; f0[i] = n_ferr[i];
        end
        send_frame(7'h5A, 1'b1);
        send_frame(7'h25, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (n_acc[i] - a0[i] !== 1 || last_byte[i] !== want[i]) begin
                failures++;
                $display("FAIL rst_realign[%0d] got n=%0d d=%h want n=1 d=%h", i, n_acc[i] - a0[i], last_byte[i], want[i]);
            end
            checks++;
            if (n_ferr[i] - f0[i] !== 0) begin
                failures++; $display("FAIL rst_realign_ferr[%0d] got %0d want 0", i, n_ferr[i] - f0[i]);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        $display("[TB] reset");
        test_reset();
        $display("[TB] basic pair");
        test_basic_pair();
        $display("[TB] frame error");
        test_frame_error();
        $display("[TB] glitch");
        test_glitch();
        $display("[TB] back to back");
        test_back_to_back();
        $display("[TB] reset mid burst");
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
